id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the 32-bit logical unit.
- Splits the instruction word, selects operand B (rs2 value or sign-extended I-immediate), and applies writeback forwarding to both operands.
- Registers A, B, opcode and func3 into a single-entry valid/ready pipeline register that drives the logical unit's inputs.
- Supports stall (back-pressure), flush, and forwarding into an entry that is held during a stall.

Parameters:
- XLEN, 32, operand/data width
- STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- rs1_data  in  XLEN  register-file read of instr[19:15]
- rs2_data  in  XLEN  register-file read of instr[24:20]
- fwd_en  in  1  writeback is writing a register this cycle
- fwd_rd  in  5  writeback destination index
- fwd_data  in  XLEN  writeback value
- flush  in  1  kill the held entry and any entry offered this cycle
- out_valid  out  1  registered entry valid
- out_ready  in  1  execute consumes the entry
- op_a  out  XLEN  to logical unit A
- op_b  out  XLEN  to logical unit B
- opcode  out  7  instr[6:0] of the held entry
- func3  out  3  instr[14:12] of the held entry
- rd  out  5  destination index
- reg_write  out  1  held entry is R-type (0110011) or I-type (0010011) with rd != 0
- stall_cnt  out  STALL_CNT_W  count of cycles with out_valid && !out_ready; saturates at all-ones

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, op_a, op_b, opcode, func3, rd, reg_write, stall_cnt and held rs1/rs2 indices all 0. Reset mid-stall discards the held entry.
- in_ready = !out_valid || out_ready, combinational. It is independent of flush.
- Capture: when in_valid && in_ready && !flush, the outputs load on the next edge. Latency is 1 cycle from acceptance to out_valid.
- Operand A at capture: if fwd_en && fwd_rd != 0 && fwd_rd == instr[19:15], use fwd_data; otherwise use rs1_data.
- Operand B at capture:
  - opcode 0010011: {{20{instr[31]}}, instr[31:20]}.
  - opcode 0110011: rs2 value with the same forwarding rule on instr[24:20].
  - Any other opcode: B = 0 and reg_write = 0. The entry still passes through so the pipeline never deadlocks.
- Stage stores rs1/rs2 indices and an is_imm flag alongside the entry.
- Held-entry forwarding: while out_valid && !out_ready, a cycle with fwd_en && fwd_rd != 0 updates the held operands on the next edge.
  - fwd_rd == held rs1 updates op_a.
  - fwd_rd == held rs2 updates op_b, only when is_imm = 0.
  - Both update if both indices match.
- Drain: out_valid && out_ready with no capture sets out_valid to 0. All other output registers hold their values.
- Simultaneous drain and capture: the new entry replaces the old with out_valid staying 1. There is no bubble.
- Flush: out_valid goes to 0 on the next edge. Flush has priority over capture and over held-entry forwarding.
- x0 handling: fwd_rd == 0 never forwards. rs1_data/rs2_data for x0 are passed through as given.
- stall_cnt increments by 1 on each cycle with out_valid && !out_ready. It holds at 2^STALL_CNT_W - 1 and is cleared only by reset.
- Outputs are all registered, with no combinational path from instr to op_a/op_b. The only combinational output is in_ready, from out_valid and out_ready.

Decomposition:
- Shared package rv_pkg holds:
  - OPCODE_R = 7'b0110011 and OPCODE_I = 7'b0010011.
  - func3 constants: XOR 100, OR 110, AND 111.
  - XLEN.
- The logical unit reuses the same package.
- One natural sub-module: operand_fwd_mux. It takes the index, register value, fwd_en, fwd_rd and fwd_data, and returns the selected value. It is instantiated twice at capture and twice for held-entry update.

Test Plan:
- R-type AND x3,x1,x2 (instr 0x0020F1B3), rs1_data=AAAAFFFF, rs2_data=0F0F0F0F, out_ready=1, no forwarding -> next cycle: out_valid=1, op_a=AAAAFFFF, op_b=0F0F0F0F, func3=111, rd=3, reg_write=1.
- ANDI x1,x2,-1 (instr 0xFFF17093), rs1_data=12345678 -> op_b=FFFFFFFF, op_a=12345678, opcode=0010011.
- Capture forwarding: same R-type AND with fwd_en=1, fwd_rd=1, fwd_data=DEADBEEF -> op_a=DEADBEEF, op_b=0F0F0F0F. Repeat with fwd_rd=0 -> no forwarding.
- Stall and held forwarding:
  - Accept R-type AND, hold out_ready=0 for 3 cycles, and in cycle 2 drive fwd_en=1, fwd_rd=2, fwd_data=00000055 -> op_b=00000055 while op_a is unchanged.
  - in_ready=0 throughout the stall, and stall_cnt=3.
  - Repeat with the ANDI -> op_b stays FFFFFFFF.
- Flush vs capture: out_valid=1, out_ready=1, in_valid=1 and flush=1 together -> next cycle out_valid=0 and nothing is captured. A back-to-back stream with out_ready=1 shows out_valid continuously 1, with no bubble.
- Reset mid-stall: assert rst_n=0 asynchronously while an entry is held -> out_valid, op_a, op_b and stall_cnt are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared RV32 decode constants for the operand stage and the
//            32-bit logical unit.
// Revision : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_R = 7'b0110011;
    localparam logic [6:0] OPCODE_I = 7'b0010011;

    localparam logic [2:0] FUNC3_XOR = 3'b100;
    localparam logic [2:0] FUNC3_OR  = 3'b110;
    localparam logic [2:0] FUNC3_AND = 3'b111;

    // Only register-register and register-immediate ALU ops write a GPR here.
    function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
        return ((opc == OPCODE_R) || (opc == OPCODE_I)) && (rd != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : operand_fwd_mux
// Purpose  : Selects writeback data over a register value when the writeback
//            destination matches the operand index (x0 never forwards).
// Revision : 1.0  initial release
// ============================================================================
module operand_fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      idx,
    input  logic [XLEN-1:0] reg_val,
    input  logic            fwd_en,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    output logic [XLEN-1:0] sel_val
);

    logic w_hit;

    assign w_hit   = fwd_en && (fwd_rd != 5'd0) && (fwd_rd == idx);
    assign sel_val = w_hit ? fwd_data : reg_val;

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Purpose  : Decode-to-execute register stage feeding the logical unit, with
//            operand-B selection, writeback forwarding, stall and flush.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic                   fwd_en,
    input  logic [4:0]             fwd_rd,
    input  logic [XLEN-1:0]        fwd_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        op_a,
    output logic [XLEN-1:0]        op_b,
    output logic [6:0]             opcode,
    output logic [2:0]             func3,
    output logic [4:0]             rd,
    output logic                   reg_write,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    import rv_pkg::*;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]      w_opc;
    logic [4:0]      w_rs1_idx;
    logic [4:0]      w_rs2_idx;
    logic [4:0]      w_rd_idx;
    logic [2:0]      w_func3;
    logic [XLEN-1:0] w_imm;

    assign w_opc     = instr[6:0];
    assign w_rd_idx  = instr[11:7];
    assign w_func3   = instr[14:12];
    assign w_rs1_idx = instr[19:15];
    assign w_rs2_idx = instr[24:20];
    assign w_imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // ------------------------------------------------------------------
    // Held entry
    // ------------------------------------------------------------------
    logic                   r_valid;
    logic [XLEN-1:0]        r_op_a;
    logic [XLEN-1:0]        r_op_b;
    logic [6:0]             r_opcode;
    logic [2:0]             r_func3;
    logic [4:0]             r_rd;
    logic                   r_reg_write;
    logic [4:0]             r_rs1;
    logic [4:0]             r_rs2;
    logic                   r_is_imm;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_capture;
    logic w_drain;
    logic w_stall;

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;
    assign w_drain   = r_valid && out_ready;
    assign w_stall   = r_valid && !out_ready;

    // ------------------------------------------------------------------
    // Forwarding muxes: two at capture, two for the held entry
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_cap_a;
    logic [XLEN-1:0] w_cap_rs2;
    logic [XLEN-1:0] w_hold_a;
    logic [XLEN-1:0] w_hold_b;

    operand_fwd_mux #(.XLEN(XLEN)) u_cap_a (
        .idx      (w_rs1_idx),
        .reg_val  (rs1_data),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .sel_val  (w_cap_a)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_cap_b (
        .idx      (w_rs2_idx),
        .reg_val  (rs2_data),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .sel_val  (w_cap_rs2)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_hold_a (
        .idx      (r_rs1),
        .reg_val  (r_op_a),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .sel_val  (w_hold_a)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_hold_b (
        .idx      (r_rs2),
        .reg_val  (r_op_b),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .sel_val  (w_hold_b)
    );

    // ------------------------------------------------------------------
    // Operand B selection at capture
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_cap_b;
    logic            w_cap_is_imm;

    always_comb begin
        w_cap_b      = '0;
        w_cap_is_imm = 1'b1;
        if (w_opc == OPCODE_I) begin
            w_cap_b = w_imm;
        end else if (w_opc == OPCODE_R) begin
            w_cap_b      = w_cap_rs2;
            w_cap_is_imm = 1'b0;
        end
    end
    // Unknown opcodes are marked is_imm so their zero B is never overwritten
    // by held-entry forwarding.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_opcode    <= '0;
            r_func3     <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_is_imm    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_op_a      <= w_cap_a;
            r_op_b      <= w_cap_b;
            r_opcode    <= w_opc;
            r_func3     <= w_func3;
            r_rd        <= w_rd_idx;
            r_reg_write <= writes_rd(w_opc, w_rd_idx);
            r_rs1       <= w_rs1_idx;
            r_rs2       <= w_rs2_idx;
            r_is_imm    <= w_cap_is_imm;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end else if (w_stall) begin
            r_op_a <= w_hold_a;
            if (!r_is_imm) begin
                r_op_b <= w_hold_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign out_valid = r_valid;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign opcode    = r_opcode;
    assign func3     = r_func3;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
